// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package   : seg7_pkg
// Purpose   : Shared constants, scan-state encoding and timer sizing helper
//             for the multiplexed seven-segment scanner.
// Revision  : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments dark, decimal point dark (active-low outputs)
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Position of the decimal point inside the segment byte
    localparam int DP_BIT = 7;

    // Scan phases: dark gap between digits, then one digit lit
    typedef enum logic [0:0] {
        S_BLANK  = 1'b0,
        S_ACTIVE = 1'b1
    } scan_state_t;

    // Bits needed for a timer that counts 0..max(dwell,blank)-1
    function automatic int timer_width(input int dwell, input int blank);
        int longest;
        longest = (dwell > blank) ? dwell : blank;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module    : seg7_decoder
// Purpose   : Hex nibble to active-low seven-segment pattern, dp left dark.
//             Bit order: bit7 = dp, bits 6..0 = g..a.
// Revision  : 1.0 - initial release
// ============================================================================
module seg7_decoder (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Pure lookup of the glyph for each hex value
    always_comb begin
        seg = 8'hFF;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scanner.sv
`default_nettype none
// ============================================================================
// Module    : seg7_scanner
// Purpose   : Time-multiplexed seven-segment display scanner with a dark gap
//             between digits, frame-atomic display updates through a pending
//             register, per-digit dp/blank and leading-zero suppression.
// Revision  : 1.0 - initial release
// ============================================================================
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic [NUM_DIGITS-1:0]   in_blank,
    input  logic                    lz_suppress,
    output logic [7:0]              seg7,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int TW = timer_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t             state;
    scan_state_t             state_nx;
    logic [TW-1:0]           timer;
    logic [TW-1:0]           timer_nx;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nx;
    logic                    frame_wrap;

    logic                    pending_valid;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;

    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic                    accept;
    logic [NUM_DIGITS-1:0]   lz_hide;
    logic [3:0]              cur_nibble;
    logic [7:0]              dec_seg;
    logic [7:0]              lit_seg;

    // A value accepted in the wrap cycle replaces the one being promoted
    assign in_ready   = !pending_valid || frame_wrap;
    assign accept     = in_valid && in_ready;
    assign frame_done = frame_wrap;

    // Scan state, phase timer and digit index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BLANK;
            timer <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic: dark gap, then dwell, then advance to the next digit
    always_comb begin
        state_nx   = state;
        timer_nx   = timer + 1'b1;
        idx_nx     = idx;
        frame_wrap = 1'b0;
        case (state)
            S_BLANK: begin
                if (timer == BLANK_LAST) begin
                    state_nx = S_ACTIVE;
                    timer_nx = '0;
                end
            end
            S_ACTIVE: begin
                if (timer == DWELL_LAST) begin
                    state_nx = S_BLANK;
                    timer_nx = '0;
                    if (idx == IDX_LAST) begin
                        idx_nx     = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_BLANK;
                timer_nx = '0;
                idx_nx   = '0;
            end
        endcase
    end

    // Pending capture on handshake; promotion to the display only at frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_valid <= 1'b0;
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_blank    <= '0;
            disp_data     <= '0;
            disp_dp       <= '0;
            disp_blank    <= '1;
        end else begin
            if (frame_wrap && pending_valid) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            if (accept) begin
                pend_data     <= in_data;
                pend_dp       <= in_dp;
                pend_blank    <= in_blank;
                pending_valid <= 1'b1;
            end else if (frame_wrap) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Digit k is a leading zero when it and every digit left of it are zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_hide  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (disp_data[4*k +: 4] == 4'h0);
            lz_hide[k] = zero_run;
        end
    end

    assign cur_nibble = disp_data[4*int'(idx) +: 4];

    seg7_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Segment pattern for the digit currently selected by idx
    always_comb begin
        lit_seg = dec_seg;
        lit_seg[DP_BIT] = ~disp_dp[idx];
        if (disp_blank[idx]) begin
            lit_seg = SEG_OFF;
        end else if (lz_suppress && lz_hide[idx]) begin
            lit_seg = SEG_OFF;
            lit_seg[DP_BIT] = ~disp_dp[idx];
        end
    end

    // Registered drivers follow the upcoming state so an/seg7 switch with it;
    // idx never changes on an edge that enters or stays in S_ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            seg7 <= SEG_OFF;
        end else if (state_nx == S_ACTIVE) begin
            an   <= ~(NUM_DIGITS'(1) << idx);
            seg7 <= lit_seg;
        end else begin
            an   <= '1;
            seg7 <= SEG_OFF;
        end
    end

endmodule
`default_nettype wire

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter DWELL_CYCLES, default 50000, clock cycles each digit is lit (>=1).
REQ-003 Parameter BLANK_CYCLES, default 500, all-off cycles between digits for ghost suppression (>=1).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  new display value offered.
REQ-007 in_ready  output  1  scanner can accept a value.
REQ-008 in_data  input  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 rightmost.
REQ-009 in_dp  input  NUM_DIGITS  per-digit decimal point enable, 1 = lit.
REQ-010 in_blank  input  NUM_DIGITS  per-digit force-off, 1 = dark.
REQ-011 lz_suppress  input  1  leading-zero suppression enable, sampled live.
REQ-012 seg7  output  8  active-low segments, bit7 = dp, bits 6..0 = g..a.
REQ-013 an  output  NUM_DIGITS  active-low digit enables, at most one low.
REQ-014 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-015 Handshake: transfer when in_valid && in_ready; data, dp and blank are captured together into a pending register.
REQ-016 in_ready = !pending_valid || frame_wrap; a value accepted in the wrap cycle becomes the new pending value.
REQ-017 Pending value is copied into the display register only on frame wrap, so a frame never shows mixed old/new digits.
REQ-018 FSM states: S_BLANK, S_ACTIVE; timer counts 0..N-1 in each state.
REQ-019 S_BLANK: an all ones, seg7 = 8'hFF; at timer == BLANK_CYCLES-1 go to S_ACTIVE with timer cleared.
REQ-020 S_ACTIVE: an = ~(1 << idx); at timer == DWELL_CYCLES-1 go to S_BLANK, timer cleared, idx increments.
REQ-021 idx wraps from NUM_DIGITS-1 to 0; that transition is frame_wrap, asserts frame_done for exactly one cycle and performs REQ-017.
REQ-022 Lit digit seg7: decoded nibble, bit7 = 0 if in_dp bit set (from display register), else 1.
REQ-023 Digit forced to 8'hFF (an still asserted) if its blank bit is set.
REQ-024 Leading-zero suppression: digit k (k>0) is 8'hFF (dp kept) when lz_suppress and nibbles NUM_DIGITS-1..k are all zero; digit 0 is never suppressed.
REQ-025 seg7 and an are registered and change on the same clock edge; digits never overlap, and each lit interval is exactly DWELL_CYCLES cycles.
REQ-026 Display register resets to all-zero nibbles with all digits blanked, so display is dark until the first frame wrap after a load.

Reset
REQ-027 While rst_n low: an all ones, seg7 = 8'hFF, frame_done = 0, in_ready = 1, pending_valid = 0, state S_BLANK, idx = 0, timer = 0.
REQ-028 Reset asserted mid-operation takes effect immediately, asynchronously; pending and display contents are discarded.
REQ-029 After release, first lit digit is digit 0, after BLANK_CYCLES cycles.

Structure
REQ-030 Shared package seg7_pkg holds SEG_OFF (8'hFF), DP_BIT (7), the scan state enum and the timer width function.
REQ-031 One sub-module: seg7_decoder instantiated once, fed the nibble selected by idx (nibble to active-low segments, dp off).

Verification (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-032 Reset: hold rst_n=0 -> an=4'b1111, seg7=8'hFF, in_ready=1, frame_done=0.
REQ-033 Load in_data=16'h12A0, dp=0, blank=0 -> after wrap: an=1110/seg7=C0, 1101/88, 1011/A4, 0111/F9, each 4 cycles, separated by 2 dark cycles.
REQ-034 Load 16'h12A0 with in_dp=4'b0001 -> digit 0 shows 8'h40; others unchanged.
REQ-035 lz_suppress=1, data 16'h0050 -> digits 3,2 = FF, digit1 = 92, digit0 = C0; data 16'h0000 -> only digit0 = C0.
REQ-036 Two back-to-back loads mid-frame -> first accepted, in_ready low, second held until frame_done cycle; display changes only at frame boundary, with no mixed frame.
REQ-037 Drop rst_n during digit-2 active window -> an=1111, seg7=FF same cycle; after release digit 0 lights first, display dark until a new load wraps.
